decode_ibuf: RTL and testbench

- Parametrised multi-lane instruction buffer between the F1 fetch stage and the decode stage; the next generation of the single-entry decoder pipeline register.
- Accepts up to ENQ_W instructions per cycle from F1 and stores them in a circular queue of DEPTH entries.
- Presents up to DEQ_W oldest entries in order to the decoder lanes, with per-lane endsim detection.
- Flush discards all contents; stall is replaced by a credit-style accept count from decode.

---
 rtl/decode_ibuf_if.sv | 36 +++
 rtl/decode_ibuf.sv | 199 +++++++++++++++++++
 tb/tb_decode_ibuf.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_ibuf_if.sv
// Signal bundle between F1 (enqueue side), decode (dequeue side) and decode_ibuf.
// master = F1/decode environment, slave = the buffer itself.
interface decode_ibuf_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEQ_W + 1);

    logic                    flush_i;
    logic [ENQ_W-1:0]        f1_valid_i;
    logic [ENQ_W*XLEN-1:0]   f1_pc_i;
    logic [ENQ_W*32-1:0]     f1_inst_i;
    logic                    f1_ready_o;
    logic [DEQ_W-1:0]        dec_valid_o;
    logic [DEQ_W*XLEN-1:0]   dec_pc_o;
    logic [DEQ_W*32-1:0]     dec_inst_o;
    logic [DEQ_W-1:0]        dec_endsim_o;
    logic [AW-1:0]           dec_accept_i;
    logic [CW-1:0]           count_o;
    logic                    halted_o;

    modport master (
        output flush_i, f1_valid_i, f1_pc_i, f1_inst_i, dec_accept_i,
        input  f1_ready_o, dec_valid_o, dec_pc_o, dec_inst_o, dec_endsim_o,
               count_o, halted_o
    );

    modport slave (
        input  flush_i, f1_valid_i, f1_pc_i, f1_inst_i, dec_accept_i,
        output f1_ready_o, dec_valid_o, dec_pc_o, dec_inst_o, dec_endsim_o,
               count_o, halted_o
    );
endinterface

// File: rtl/decode_ibuf.sv
// Multi-lane circular instruction buffer between F1 and decode with per-lane endsim detect.
// Optional sticky endsim halt is built when DECODE_IBUF_ENDSIM_HALT_EN is defined.

module decode_ibuf_chk #(
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int CW    = 4
) (
    input logic             clk,
    input logic             rst,
    input logic [ENQ_W-1:0] f1_valid,
    input logic [CW-1:0]    count
);
    logic [ENQ_W-1:0] valid_inc_s;

    assign valid_inc_s = f1_valid + ENQ_W'(1);

    // A prefix mask 0..01..1 plus one has no bits in common with itself.
    a_prefix_mask: assert property (@(posedge clk) disable iff (rst)
        ((f1_valid & valid_inc_s) == {ENQ_W{1'b0}}));

    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        (count <= CW'(DEPTH)));
endmodule

module decode_ibuf #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 8,
    parameter int ENQ_W = 2,
    parameter int DEQ_W = 2
) (
    input logic          clk,
    input logic          rst,
    decode_ibuf_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = XLEN + 32;
    localparam logic [31:0] ENDSIM_INST = 32'h0000_006b;

    // Each slot holds {pc, inst}.
    logic [EW-1:0]          mem_r [DEPTH];
    logic [PW-1:0]          head_r;
    logic [PW-1:0]          tail_r;
    logic [CW-1:0]          count_r;

    logic                   halted_s;
    logic [CW-1:0]          free_s;
    logic                   ready_s;
    logic                   enq_en_s;
    logic [CW-1:0]          n_enq_s;
    logic [CW-1:0]          n_valid_s;
    logic [CW-1:0]          accept_s;
    logic [CW-1:0]          n_deq_raw_s;
    logic [CW-1:0]          n_deq_s;
    logic [CW-1:0]          count_next_s;
    logic [DEQ_W-1:0]       lane_valid_s;
    logic [DEQ_W-1:0]       lane_endsim_s;
    logic [DEQ_W*XLEN-1:0]  lane_pc_s;
    logic [DEQ_W*32-1:0]    lane_inst_s;

    function automatic logic [CW-1:0] popcount_enq(input logic [ENQ_W-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int k = 0; k < ENQ_W; k++) begin
            n = n + CW'(v[k]);
        end
        return n;
    endfunction

    // Enqueue admission: a whole group must fit, judged on the registered count only.
    always_comb begin
        free_s = CW'(DEPTH) - count_r;
        if (halted_s) begin
            ready_s = 1'b0;
        end else begin
            ready_s = (free_s >= CW'(ENQ_W));
        end
        enq_en_s = ready_s & ~bus.flush_i;
        if (enq_en_s) begin
            n_enq_s = popcount_enq(bus.f1_valid_i);
        end else begin
            n_enq_s = {CW{1'b0}};
        end
    end

    // Present the oldest entries; invalid lanes read as zero.
    always_comb begin
        lane_valid_s  = {DEQ_W{1'b0}};
        lane_endsim_s = {DEQ_W{1'b0}};
        lane_pc_s     = {(DEQ_W*XLEN){1'b0}};
        lane_inst_s   = {(DEQ_W*32){1'b0}};
        n_valid_s     = {CW{1'b0}};
        for (int k = 0; k < DEQ_W; k++) begin
            if (!halted_s && (count_r > CW'(k))) begin
                lane_valid_s[k]        = 1'b1;
                lane_pc_s[k*XLEN +: XLEN] = mem_r[head_r + PW'(k)][EW-1:32];
                lane_inst_s[k*32 +: 32]   = mem_r[head_r + PW'(k)][31:0];
                lane_endsim_s[k]       = (mem_r[head_r + PW'(k)][31:0] == ENDSIM_INST);
                n_valid_s              = n_valid_s + CW'(1);
            end else begin
                lane_valid_s[k]  = 1'b0;
                lane_endsim_s[k] = 1'b0;
            end
        end
    end

    // Clamp the decode accept to the lanes actually presented.
    always_comb begin
        accept_s = CW'(bus.dec_accept_i);
        if (accept_s < n_valid_s) begin
            n_deq_raw_s = accept_s;
        end else begin
            n_deq_raw_s = n_valid_s;
        end
    end

`ifdef DECODE_IBUF_ENDSIM_HALT_EN
    logic          halted_r;
    logic          halt_set_s;
    logic [CW-1:0] clip_s;

    // Stop consuming right after the oldest accepted endsim lane; scan downwards so the lowest hit wins.
    always_comb begin
        clip_s     = n_deq_raw_s;
        halt_set_s = 1'b0;
        for (int k = DEQ_W - 1; k >= 0; k--) begin
            clip_s     = (lane_endsim_s[k] && (CW'(k) < n_deq_raw_s)) ? CW'(k + 1) : clip_s;
            halt_set_s = halt_set_s | (lane_endsim_s[k] && (CW'(k) < n_deq_raw_s));
        end
        n_deq_s = clip_s;
    end

    // Sticky halt flag, cleared only by reset or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            halted_r <= 1'b0;
        end else if (bus.flush_i) begin
            halted_r <= 1'b0;
        end else if (halt_set_s) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign halted_s = halted_r;
`else
    assign n_deq_s  = n_deq_raw_s;
    assign halted_s = 1'b0;
`endif

    assign count_next_s = count_r + n_enq_s - n_deq_s;

    // Pointer and occupancy state; flush empties the queue regardless of traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (bus.flush_i) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            head_r  <= head_r + PW'(n_deq_s);
            tail_r  <= tail_r + PW'(n_enq_s);
            count_r <= count_next_s;
        end
    end

    // Storage write; lane k of a prefix group lands at tail+k.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_W; k++) begin
            if (enq_en_s && bus.f1_valid_i[k]) begin
                mem_r[tail_r + PW'(k)] <= {bus.f1_pc_i[k*XLEN +: XLEN], bus.f1_inst_i[k*32 +: 32]};
            end
        end
    end

    assign bus.f1_ready_o   = ready_s;
    assign bus.dec_valid_o  = lane_valid_s;
    assign bus.dec_pc_o     = lane_pc_s;
    assign bus.dec_inst_o   = lane_inst_s;
    assign bus.dec_endsim_o = lane_endsim_s;
    assign bus.count_o      = count_r;
    assign bus.halted_o     = halted_s;

    decode_ibuf_chk #(
        .DEPTH (DEPTH),
        .ENQ_W (ENQ_W),
        .CW    (CW)
    ) u_chk (
        .clk      (clk),
        .rst      (rst),
        .f1_valid (bus.f1_valid_i),
        .count    (count_r)
    );
endmodule

// File: tb/tb_decode_ibuf.sv
// Randomised and directed bench for decode_ibuf against a queue-based reference model.
module tb_decode_ibuf;
    localparam int XLEN  = 64;
    localparam int DEPTH = 8;
    localparam int ENQ_W = 2;
    localparam int DEQ_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    decode_ibuf_if #(.XLEN(XLEN), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) bus ();

    decode_ibuf #(.XLEN(XLEN), .DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference model: the queue contents in age order plus the halt flag.
    logic [63:0] q_pc[$];
    logic [31:0] q_inst[$];
    bit          m_halt;
    int          n_cmp;
    int          n_fail;
    bit          chk_en;
    logic [63:0] pc_seq;
    logic [63:0] exp_pc;

    function automatic bit m_ready();
        return !m_halt && ((DEPTH - q_pc.size()) >= ENQ_W);
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int          sz;
        bit          ev;
        logic [63:0] epc;
        logic [31:0] ei;
        sz = q_pc.size();
        cmp("f1_ready", 64'(bus.f1_ready_o), 64'(m_ready()));
        cmp("count", 64'(bus.count_o), 64'(sz));
        cmp("halted", 64'(bus.halted_o), 64'(m_halt));
        for (int k = 0; k < DEQ_W; k++) begin
            ev = !m_halt && (sz > k);
            if (ev) begin
                epc = q_pc[k];
                ei  = q_inst[k];
            end else begin
                epc = 64'h0;
                ei  = 32'h0;
            end
            cmp($sformatf("valid%0d", k), 64'(bus.dec_valid_o[k]), 64'(ev));
            cmp($sformatf("pc%0d", k), bus.dec_pc_o[k*XLEN +: XLEN], epc);
            cmp($sformatf("inst%0d", k), 64'(bus.dec_inst_o[k*32 +: 32]), 64'(ei));
            cmp($sformatf("endsim%0d", k), 64'(bus.dec_endsim_o[k]), 64'(ev && (ei == 32'h0000_006b)));
        end
    endtask

    // Apply the specification's edge rules to the model using the inputs the DUT just sampled.
    task automatic model_edge();
        int nv;
        int nd;
        bit rdy;
        bit hit;
        if (rst || bus.flush_i) begin
            q_pc.delete();
            q_inst.delete();
            m_halt = 1'b0;
            return;
        end
        rdy = m_ready();
        nv  = m_halt ? 0 : ((q_pc.size() < DEQ_W) ? q_pc.size() : DEQ_W);
        nd  = (int'(bus.dec_accept_i) < nv) ? int'(bus.dec_accept_i) : nv;
        hit = 1'b0;
`ifdef DECODE_IBUF_ENDSIM_HALT_EN
        for (int k = 0; k < nd; k++) begin
            if (q_inst[k] == 32'h0000_006b) begin
                nd  = k + 1;
                hit = 1'b1;
                break;
            end
        end
`endif
        repeat (nd) begin
            void'(q_pc.pop_front());
            void'(q_inst.pop_front());
        end
        if (hit) m_halt = 1'b1;
        if (rdy) begin
            for (int k = 0; k < ENQ_W; k++) begin
                if (bus.f1_valid_i[k]) begin
                    q_pc.push_back(bus.f1_pc_i[k*XLEN +: XLEN]);
                    q_inst.push_back(bus.f1_inst_i[k*32 +: 32]);
                end
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        if (chk_en) compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_i(input int n, input int acc, input bit fl, input logic [31:0] i0, input logic [31:0] i1);
        bus.f1_valid_i   = ENQ_W'((1 << n) - 1);
        bus.f1_pc_i      = {pc_seq + 64'd4, pc_seq};
        bus.f1_inst_i    = {i1, i0};
        bus.dec_accept_i = 2'(acc);
        bus.flush_i      = fl;
        pc_seq           = pc_seq + 64'(4 * n);
        cycle();
    endtask

    task automatic drv(input int n, input int acc, input bit fl);
        drive_i(n, acc, fl, 32'h0000_0013, 32'h0000_0013);
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        chk_en = 1'b0;
        m_halt = 1'b0;
        pc_seq = 64'h1000;
        bus.flush_i      = 1'b0;
        bus.f1_valid_i   = '0;
        bus.f1_pc_i      = '0;
        bus.f1_inst_i    = '0;
        bus.dec_accept_i = '0;
        rst = 1'b1;
        cycle();
        cycle();
        rst    = 1'b0;
        chk_en = 1'b1;
        cmp("rst_count", 64'(bus.count_o), 64'd0);
        cmp("rst_ready", 64'(bus.f1_ready_o), 64'd1);
        cmp("rst_valid", 64'(bus.dec_valid_o), 64'd0);
        cmp("rst_halted", 64'(bus.halted_o), 64'd0);

        // 1: two-lane enqueue becomes visible after one edge.
        drive_i(2, 0, 1'b0, 32'h0000_0013, 32'h0010_0093);
        cmp("t1_valid", 64'(bus.dec_valid_o), 64'h3);
        cmp("t1_pc0", bus.dec_pc_o[63:0], 64'h1000);
        cmp("t1_pc1", bus.dec_pc_o[127:64], 64'h1004);
        cmp("t1_inst1", 64'(bus.dec_inst_o[63:32]), 64'h0010_0093);
        cmp("t1_count", 64'(bus.count_o), 64'd2);

        // 2: fill, drop at count 7, full at 8, drain by two.
        drv(2, 0, 1'b0);
        drv(2, 0, 1'b0);
        drv(1, 0, 1'b0);
        cmp("t2_ready7", 64'(bus.f1_ready_o), 64'd0);
        drv(2, 0, 1'b0);
        cmp("t2_drop_count", 64'(bus.count_o), 64'd7);
        drv(0, 1, 1'b0);
        drv(2, 0, 1'b0);
        cmp("t2_count8", 64'(bus.count_o), 64'd8);
        cmp("t2_ready8", 64'(bus.f1_ready_o), 64'd0);
        drv(2, 2, 1'b0);
        cmp("t2_count6", 64'(bus.count_o), 64'd6);
        cmp("t2_ready6", 64'(bus.f1_ready_o), 64'd1);

        // 3: head ends at slot 7 so the two lanes straddle the wrap.
        drv(0, 0, 1'b1);
        pc_seq = 64'h2000;
        drv(2, 0, 1'b0);
        drv(2, 0, 1'b0);
        drv(2, 0, 1'b0);
        drv(2, 2, 1'b0);
        drv(0, 2, 1'b0);
        drv(2, 2, 1'b0);
        drv(0, 1, 1'b0);
        cmp("t3_count", 64'(bus.count_o), 64'd3);
        cmp("t3_pc0", bus.dec_pc_o[63:0], 64'h201c);
        cmp("t3_pc1", bus.dec_pc_o[127:64], 64'h2020);

        // 4: flush beats a same-cycle enqueue and accept.
        drv(1, 0, 1'b0);
        cmp("t4_count4", 64'(bus.count_o), 64'd4);
        drv(2, 2, 1'b1);
        cmp("t4_count", 64'(bus.count_o), 64'd0);
        cmp("t4_valid", 64'(bus.dec_valid_o), 64'd0);
        cmp("t4_ready", 64'(bus.f1_ready_o), 64'd1);
        exp_pc = pc_seq;
        drv(1, 0, 1'b0);
        cmp("t4_newpc", bus.dec_pc_o[63:0], exp_pc);

        // 5: endsim in lane 1 of a two-lane accept.
        drv(0, 0, 1'b1);
        drive_i(2, 0, 1'b0, 32'h0000_0013, 32'h0000_006b);
        drv(1, 0, 1'b0);
        cmp("t5_endsim", 64'(bus.dec_endsim_o), 64'h2);
        drv(0, 2, 1'b0);
        cmp("t5_count", 64'(bus.count_o), 64'd1);
`ifdef DECODE_IBUF_ENDSIM_HALT_EN
        cmp("t5_halted", 64'(bus.halted_o), 64'd1);
        drv(0, 2, 1'b0);
        cmp("t5_frozen", 64'(bus.count_o), 64'd1);
        cmp("t5_hvalid", 64'(bus.dec_valid_o), 64'd0);
        cmp("t5_hready", 64'(bus.f1_ready_o), 64'd0);
`else
        cmp("t5_halted", 64'(bus.halted_o), 64'd0);
`endif
        drv(0, 0, 1'b1);
        cmp("t5_unhalt", 64'(bus.halted_o), 64'd0);

        // 6: accept clamps to one while a new entry arrives.
        drv(1, 0, 1'b0);
        exp_pc = pc_seq;
        drv(1, 2, 1'b0);
        cmp("t6_count", 64'(bus.count_o), 64'd1);
        cmp("t6_valid", 64'(bus.dec_valid_o), 64'h1);
        cmp("t6_pc0", bus.dec_pc_o[63:0], exp_pc);

        // Random traffic with occasional flush and reset.
        for (int c = 0; c < 3000; c++) begin
            int n;
            n = int'($urandom % 3);
            bus.f1_valid_i = ENQ_W'((1 << n) - 1);
            bus.f1_pc_i    = {$urandom, $urandom, $urandom, $urandom};
            for (int k = 0; k < ENQ_W; k++) begin
                bus.f1_inst_i[k*32 +: 32] = (($urandom % 12) == 0) ? 32'h0000_006b : 32'($urandom);
            end
            bus.dec_accept_i = 2'($urandom % 4);
            bus.flush_i      = (($urandom % 32) == 0);
            rst              = (($urandom % 300) == 0);
            cycle();
        end
        rst = 1'b0;
        bus.flush_i = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
